// File: rtl/logic_op_pkg.sv
// logic_op_pkg: opcode encoding shared by the logic_op_pipe ALU and pipeline
package logic_op_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ANDN, OP_PASS
    } op_e;
endpackage

// File: rtl/logic_op_alu.sv
// logic_op_alu: combinational eight-function bitwise unit
module logic_op_alu import logic_op_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] r
);
    // select one bitwise function of a and b; PASS ignores b
    always_comb begin
        r = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            OP_PASS: r = a;
        endcase
    end
endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: registered bitwise op with valid/ready, sticky OR accumulator
// and saturating all-ones counter; LOGIC_OP_PIPE_PARITY_EN adds y_par output
module logic_op_pipe import logic_op_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_red,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] hit_cnt
`ifdef LOGIC_OP_PIPE_PARITY_EN
    ,
    output logic             y_par
`endif
);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             accept;
    logic             cnt_inc;

    logic_op_alu #(.WIDTH(WIDTH)) u_alu (.a(a), .b(b), .op(op_e'(op)), .r(r));

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // clear takes effect before the new result is folded in
    always_comb begin
        acc_base = acc_clr ? '0 : acc;
        cnt_base = acc_clr ? '0 : hit_cnt;
        cnt_inc  = accept & (&r) & ~(&cnt_base);
    end

    // output register: load on accept, drain when consumer takes it, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_red     <= 1'b0;
`ifdef LOGIC_OP_PIPE_PARITY_EN
            y_par     <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= r;
            y_red     <= &r;
`ifdef LOGIC_OP_PIPE_PARITY_EN
            y_par     <= ^r;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // sticky OR accumulator and saturating all-ones hit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            hit_cnt <= '0;
        end else if (accept || acc_clr) begin
            acc     <= acc_base | (accept ? r : '0);
            hit_cnt <= cnt_base + CNT_W'(cnt_inc);
        end
    end
endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: directed self-checking bench for logic_op_pipe
module tb_logic_op_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       acc_clr = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready, out_valid, y_red;
    logic [7:0] y, acc, hit_cnt;
    logic       in_ready2, out_valid2, y_red2;
    logic [7:0] y2, acc2;
    logic [1:0] hit_cnt2;
`ifdef LOGIC_OP_PIPE_PARITY_EN
    logic       y_par, y_par2;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_op_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .y_red(y_red), .acc(acc), .hit_cnt(hit_cnt)
`ifdef LOGIC_OP_PIPE_PARITY_EN
        , .y_par(y_par)
`endif
    );

    logic_op_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid2),
        .out_ready(out_ready), .y(y2), .y_red(y_red2), .acc(acc2), .hit_cnt(hit_cnt2)
`ifdef LOGIC_OP_PIPE_PARITY_EN
        , .y_par(y_par2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got %h exp 00", y); end
        checks++; if (y_red !== 1'b0) begin errors++; $display("FAIL reset_y_red got %b exp 0", y_red); end
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc got %h exp 00", acc); end
        checks++; if (hit_cnt !== 8'h00) begin errors++; $display("FAIL reset_hit_cnt got %h exp 00", hit_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
`ifdef LOGIC_OP_PIPE_PARITY_EN
        checks++; if (y_par !== 1'b0) begin errors++; $display("FAIL reset_y_par got %b exp 0", y_par); end
`endif
    endtask

    task automatic test_opcodes();
        logic [7:0] exp_y [8];
        exp_y = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};
        a = 8'hF0;
        b = 8'hCC;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            checks++; if (y !== exp_y[i] || out_valid !== 1'b1) begin errors++; $display("FAIL opcode_%0d got y=%h v=%b exp y=%h v=1", i, y, out_valid, exp_y[i]); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || y !== 8'hF0) begin errors++; $display("FAIL drain got v=%b y=%h exp v=0 y=f0", out_valid, y); end
        checks++; if (acc !== 8'hFF || hit_cnt !== 8'd0) begin errors++; $display("FAIL sweep_acc got acc=%h hit=%0d exp acc=ff hit=0", acc, hit_cnt); end
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        checks++; if (acc !== 8'h00 || y !== 8'hF0 || out_valid !== 1'b0) begin errors++; $display("FAIL clear_only got acc=%h y=%h v=%b exp acc=00 y=f0 v=0", acc, y, out_valid); end
    endtask

    task automatic test_backpressure();
        op = 3'd0; a = 8'hFF; b = 8'hFF;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (y !== 8'hFF || y_red !== 1'b1 || hit_cnt !== 8'd1) begin errors++; $display("FAIL bp_load got y=%h red=%b hit=%0d exp y=ff red=1 hit=1", y, y_red, hit_cnt); end
        op = 3'd1; a = 8'h00; b = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d got %b exp 0", i, in_ready); end
            tick();
            checks++; if (y !== 8'hFF || y_red !== 1'b1 || out_valid !== 1'b1 || acc !== 8'hFF || hit_cnt !== 8'd1) begin errors++; $display("FAIL bp_hold_%0d got y=%h red=%b v=%b acc=%h hit=%0d exp y=ff red=1 v=1 acc=ff hit=1", i, y, y_red, out_valid, acc, hit_cnt); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (y !== 8'h00 || y_red !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_next got y=%h red=%b v=%b exp y=00 red=0 v=1", y, y_red, out_valid); end
        in_valid = 1'b0;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        checks++; if (out_valid !== 1'b0 || acc !== 8'h00 || hit_cnt !== 8'd0) begin errors++; $display("FAIL bp_end got v=%b acc=%h hit=%0d exp v=0 acc=00 hit=0", out_valid, acc, hit_cnt); end
    endtask

    task automatic test_accumulator();
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 3'd1; a = 8'h01; b = 8'h00;
        tick();
        checks++; if (acc !== 8'h01) begin errors++; $display("FAIL acc_1 got %h exp 01", acc); end
        a = 8'h80;
        tick();
        checks++; if (acc !== 8'h81) begin errors++; $display("FAIL acc_2 got %h exp 81", acc); end
        op = 3'd2; a = 8'hFF;
        tick();
        checks++; if (acc !== 8'hFF || hit_cnt !== 8'd1 || y !== 8'hFF) begin errors++; $display("FAIL acc_3 got acc=%h hit=%0d y=%h exp acc=ff hit=1 y=ff", acc, hit_cnt, y); end
        acc_clr = 1'b1;
        op = 3'd0; a = 8'h0F; b = 8'h0F;
        tick();
        acc_clr = 1'b0;
        checks++; if (acc !== 8'h0F || hit_cnt !== 8'd0) begin errors++; $display("FAIL acc_clr_accept got acc=%h hit=%0d exp acc=0f hit=0", acc, hit_cnt); end
        checks++; if (y !== 8'h0F || out_valid !== 1'b1) begin errors++; $display("FAIL acc_clr_y got y=%h v=%b exp y=0f v=1", y, out_valid); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat [5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        op = 3'd1; a = 8'hFF; b = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (hit_cnt2 !== exp_sat[i]) begin errors++; $display("FAIL sat_%0d got %0d exp %0d", i, hit_cnt2, exp_sat[i]); end
            checks++; if (hit_cnt !== 8'(i + 1)) begin errors++; $display("FAIL wide_cnt_%0d got %0d exp %0d", i, hit_cnt, i + 1); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_midreset();
        op = 3'd2; a = 8'h07; b = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || y !== 8'h07) begin errors++; $display("FAIL mr_load got v=%b y=%h exp v=1 y=07", out_valid, y); end
`ifdef LOGIC_OP_PIPE_PARITY_EN
        checks++; if (y_par !== 1'b1) begin errors++; $display("FAIL mr_par got %b exp 1", y_par); end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || y !== 8'h00 || y_red !== 1'b0 || acc !== 8'h00 || hit_cnt !== 8'd0) begin errors++; $display("FAIL mr_async got v=%b y=%h red=%b acc=%h hit=%0d exp all 0", out_valid, y, y_red, acc, hit_cnt); end
`ifdef LOGIC_OP_PIPE_PARITY_EN
        checks++; if (y_par !== 1'b0) begin errors++; $display("FAIL mr_par_rst got %b exp 0", y_par); end
`endif
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mr_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_opcodes();
        test_backpressure();
        test_accumulator();
        test_saturation();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
